// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data hazards, taken branches and SRAM waits.
// Define FORWARDING_EN when a forwarding unit exists (only load-use hazards then stall).
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDRESS_LEN = 4,
    parameter int unsigned MEM_TIMEOUT     = 15,
    parameter int unsigned PERF_CNT_LEN    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDRESS_LEN-1:0] id_src1,
    input  logic [REG_ADDRESS_LEN-1:0] id_src2,
    input  logic                       id_src1_en,
    input  logic                       id_two_src,
    input  logic [REG_ADDRESS_LEN-1:0] ex_dest,
    input  logic                       ex_wb_en,
    input  logic                       ex_mem_read_en,
    input  logic [REG_ADDRESS_LEN-1:0] mem_dest,
    input  logic                       mem_wb_en,
    input  logic                       branch_taken,
    input  logic                       mem_req,
    input  logic                       mem_ready,
    output logic                       pc_freeze,
    output logic                       if_id_freeze,
    output logic                       if_id_flush,
    output logic                       id_ex_flush,
    output logic                       pipe_freeze,
    output logic                       mem_timeout_err,
    output logic [PERF_CNT_LEN-1:0]    stall_cycles
);

    typedef enum logic {StRun, StMemWait} state_e;

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [PERF_CNT_LEN-1:0] stall_q, stall_d;
    logic                    timeout_hit;
    logic                    hz;

`ifdef FORWARDING_EN
    logic match1, match2;
    logic unused_mem;
    assign match1     = id_src1_en && (id_src1 == ex_dest);
    assign match2     = id_two_src && (id_src2 == ex_dest);
    assign hz         = ex_mem_read_en && ex_wb_en && (match1 || match2);
    assign unused_mem = ^{mem_dest, mem_wb_en};
`else
    logic ex_match, mem_match;
    logic unused_ld;
    // ALU results are not forwarded, so any pending writer in EX or MEM blocks ID.
    assign ex_match  = (id_src1_en && (id_src1 == ex_dest)) || (id_two_src && (id_src2 == ex_dest));
    assign mem_match = (id_src1_en && (id_src1 == mem_dest)) ||
                       (id_two_src && (id_src2 == mem_dest));
    assign hz        = (ex_wb_en && ex_match) || (mem_wb_en && mem_match);
    assign unused_ld = ex_mem_read_en;
`endif

    assign timeout_hit = (state_q == StMemWait) && (cnt_q == 8'(MEM_TIMEOUT));

    always_comb begin
        pipe_freeze = ((state_q == StRun) && mem_req && !mem_ready) ||
                      ((state_q == StMemWait) && !mem_ready && !timeout_hit);
        pc_freeze    = 1'b0;
        if_id_freeze = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        // EX is held during a memory freeze, so branch/hazard are re-evaluated afterwards.
        if (pipe_freeze) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (hz) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        stall_d = stall_q;
        unique case (state_q)
            StRun: begin
                if (mem_req && !mem_ready) begin
                    state_d = StMemWait;
                    cnt_d   = 8'd1;
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                    cnt_d   = 8'd0;
                end else if (timeout_hit) begin
                    state_d = StRun;
                    cnt_d   = 8'd0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StRun;
        endcase
        if ((pc_freeze || pipe_freeze) && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            stall_q <= stall_d;
        end
    end

    assign mem_timeout_err = err_q;
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: hazard vector table plus memory-wait, timeout,
// reset and counter-saturation sequences.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, ex_dest, mem_dest;
    logic       id_src1_en, id_two_src, ex_wb_en, ex_mem_read_en, mem_wb_en;
    logic       branch_taken, mem_req, mem_ready;
    logic       pc_freeze, if_id_freeze, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout_err;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_src1        (id_src1),
        .id_src2        (id_src2),
        .id_src1_en     (id_src1_en),
        .id_two_src     (id_two_src),
        .ex_dest        (ex_dest),
        .ex_wb_en       (ex_wb_en),
        .ex_mem_read_en (ex_mem_read_en),
        .mem_dest       (mem_dest),
        .mem_wb_en      (mem_wb_en),
        .branch_taken   (branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_freeze      (pc_freeze),
        .if_id_freeze   (if_id_freeze),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .pipe_freeze    (pipe_freeze),
        .mem_timeout_err(mem_timeout_err),
        .stall_cycles   (stall_cycles)
    );

    typedef struct packed {
        logic [3:0] src1;
        logic [3:0] src2;
        logic       src1_en;
        logic       two_src;
        logic [3:0] exd;
        logic       ex_wb;
        logic       ex_rd;
        logic [3:0] memd;
        logic       mem_wb;
        logic       br;
        logic [3:0] exp_nofwd;  // {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush}
        logic [3:0] exp_fwd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        id_src1 = 4'd0; id_src2 = 4'd0; id_src1_en = 1'b0; id_two_src = 1'b0;
        ex_dest = 4'd0; ex_wb_en = 1'b0; ex_mem_read_en = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Compare combinational controls and advance the stall-cycle model.
    task automatic chk_comb(input string name, input logic [3:0] exp_ctl, input logic exp_pf);
        chk({name, " ctl"}, {28'd0, pc_freeze, if_id_freeze, if_id_flush, id_ex_flush},
            {28'd0, exp_ctl});
        chk({name, " pipe_freeze"}, {31'd0, pipe_freeze}, {31'd0, exp_pf});
        if ((exp_ctl[3] || exp_pf) && exp_stall < 65535) exp_stall++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mem_req = 1'b1;
        branch_taken = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle();
        exp_stall = 0;
    endtask

    initial begin
        vecs[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'b1101, 4'b1101};
        vecs[2]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'b1101, 4'b0000};
        vecs[3]  = '{4'd0, 4'd5, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'b1101, 4'b0000};
        vecs[4]  = '{4'd0, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[5]  = '{4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 4'b0011, 4'b0011};
        vecs[6]  = '{4'd1, 4'd2, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd8, 1'b1, 1'b1, 4'b0011, 4'b0011};
        vecs[7]  = '{4'd15, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'b1101, 4'b1101};
        vecs[8]  = '{4'd6, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[9]  = '{4'd9, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[10] = '{4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0, 4'b0000, 4'b0000};

        rst = 1'b1;
        idle();
        do_reset();

        // Reset state: idle inputs give all-zero controls and RUN state (no pipe_freeze).
        #1;
        chk_comb("reset", 4'b0000, 1'b0);
        chk("reset stall_cycles", {16'd0, stall_cycles}, 32'd0);
        chk("reset err", {31'd0, mem_timeout_err}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            idle();
            id_src1 = vecs[i].src1; id_src2 = vecs[i].src2;
            id_src1_en = vecs[i].src1_en; id_two_src = vecs[i].two_src;
            ex_dest = vecs[i].exd; ex_wb_en = vecs[i].ex_wb; ex_mem_read_en = vecs[i].ex_rd;
            mem_dest = vecs[i].memd; mem_wb_en = vecs[i].mem_wb; branch_taken = vecs[i].br;
            #1;
`ifdef FORWARDING_EN
            chk_comb($sformatf("vec%0d", i), vecs[i].exp_fwd, 1'b0);
`else
            chk_comb($sformatf("vec%0d", i), vecs[i].exp_nofwd, 1'b0);
`endif
        end
        @(negedge clk);
        idle();
        chk("table stall_cycles", {16'd0, stall_cycles}, exp_stall);

        // SRAM wait: ready on 4th cycle, branch during the freeze must not flush.
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            mem_req = 1'b1;
            mem_ready = (c == 4);
            branch_taken = (c < 4);
            #1;
            if (c < 4) chk_comb($sformatf("memwait c%0d", c), 4'b1100, 1'b1);
            else chk_comb("memwait ready", 4'b0000, 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        chk_comb("after ready", 4'b0000, 1'b0);
        chk("memwait stall_cycles", {16'd0, stall_cycles}, exp_stall);

        // Reset mid-wait abandons the access without raising an error.
        @(negedge clk);
        mem_req = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        #1;
        chk_comb("reset midwait", 4'b0000, 1'b0);
        chk("reset midwait err", {31'd0, mem_timeout_err}, 32'd0);

        // Timeout: ready never comes; freeze lasts 15 cycles, error sticks until reset.
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            mem_req = 1'b1;
            #1;
            if (c <= 15) chk_comb($sformatf("timeout c%0d", c), 4'b1100, 1'b1);
            else chk_comb("timeout hit", 4'b0000, 1'b0);
        end
        @(negedge clk);
        idle();
        #1;
        chk("timeout err set", {31'd0, mem_timeout_err}, 32'd1);
        chk_comb("after timeout", 4'b0000, 1'b0);
        repeat (5) @(negedge clk);
        chk("timeout err sticky", {31'd0, mem_timeout_err}, 32'd1);
        chk("timeout stall_cycles", {16'd0, stall_cycles}, exp_stall);
        do_reset();
        #1;
        chk("err cleared by reset", {31'd0, mem_timeout_err}, 32'd0);

        // Saturation: a persistent load-use hazard held for 2^16+5 cycles.
        @(negedge clk);
        id_src1 = 4'd3; id_src1_en = 1'b1; ex_dest = 4'd3; ex_wb_en = 1'b1; ex_mem_read_en = 1'b1;
        #1;
        chk_comb("sat hazard", 4'b1101, 1'b0);
        repeat (65541) @(negedge clk);
        chk("stall_cycles saturated", {16'd0, stall_cycles}, 32'h0000FFFF);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
